nor_rr_arbiter: RTL
===================

# nor_rr_arbiter

Shares one `nor_4bits` datapath between two requesters using round-robin arbitration. Each requester uses a valid/ready handshake. The block registers the result with the winning requester's ID and holds it until the consumer accepts it. It also keeps a per-requester count of accepted operations. It sits between lab-level stimulus sources (switch banks, test sequencers) and the shared NOR unit.

## Interface
- `WIDTH`, 4: operand and result width; must match the `nor_4bits` instance.
- `CNT_W`, 8: width of each accepted-operation counter.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 presents an operand pair.
- `req0_a`, `req0_b` in WIDTH: requester 0 operands.
- `req0_ready` out 1: requester 0 transfer is accepted this cycle.
- `req1_valid`, `req1_a`, `req1_b`, `req1_ready`: same set of signals for requester 1.
- `res_valid` out 1: result register holds an unconsumed result.
- `res_y` out WIDTH: registered `~(a | b)` of the granted pair.
- `res_id` out 1: requester that produced `res_y`.
- `res_ready` in 1: consumer accepts the result.
- `cnt0`, `cnt1` out CNT_W: accepted transfers per requester.

## Operation
- Slot free: `free = !res_valid || res_ready`.
- Grant (combinational, from the current valids and `last`):
  - only one requester valid: grant goes to it;
  - both valid: grant goes to `!last`;
  - none valid: no grant.
- `reqN_ready = free && grantN`. At most one ready is high per cycle. A ready never depends on the other requester's operands.
- Transfer on requester N means `reqN_valid && reqN_ready`. On a transfer, at the next edge:
  - `res_y <= ~(a_N | b_N)`, computed through the `nor_4bits` instance fed by a grant-selected mux;
  - `res_id <= N`;
  - `res_valid <= 1`;
  - `last <= N`;
  - `cntN <= cntN + 1`, wrapping from 2^CNT_W−1 to 0.
- No transfer while `res_valid && res_ready`: `res_valid <= 0`. `res_y` and `res_id` keep their last values.
- Consume and accept in the same cycle: the new result replaces the old one and `res_valid` stays 1. No bubble.
- `res_valid && !res_ready` (stall): `res_y`, `res_id` and `res_valid` are held. Both readies are 0.
- State encoding for the output register: EMPTY (`res_valid` = 0) and FULL (`res_valid` = 1).
  - EMPTY→FULL on a transfer.
  - FULL→EMPTY on consume without a transfer.
  - FULL→FULL on stall, or on consume plus transfer.
- Requesters must hold `valid` and operands stable until ready. The block does not check this.

## Timing
- Reset values (asynchronous on `rst_n` low, held until release): `res_valid` = 0, `res_y` = 0, `res_id` = 0, `last` = 1 (requester 0 wins the first contention), `cnt0` = `cnt1` = 0.
- While `rst_n` is low, both readies are 0, because readies are gated by `rst_n`.
- Reset asserted mid-operation discards any held result. No partial update survives.
- Latency: a transfer at edge k makes `res_valid` = 1 with the correct `res_y` and `res_id` after edge k.
- Throughput: one result per cycle while the consumer holds `res_ready` = 1.
- Fairness: under continuous contention, grants alternate 0,1,0,1. Neither requester waits more than one transfer.
- Readies are combinational from `req*_valid`, `res_valid`, `res_ready` and `last`. No other combinational path to outputs.

## Structure
- Shared include file: `WIDTH` default, the EMPTY/FULL encoding, and the requester ID constants `ID0` = 0 and `ID1` = 1.
- One sub-module: the existing `nor_4bits`, instantiated once. Its inputs come from the grant-selected operand mux.
- Arbiter, output register and counters stay inline. Expected size is about 150 lines of RTL.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-stream with `res_valid` = 1 → all outputs 0 immediately, both readies 0. After release, the first contention grants requester 0.
- **Single requester:** req0 sends a=0101, b=0011 with `res_ready` = 1 → one cycle later `res_valid` = 1, `res_y` = 1000, `res_id` = 0, `cnt0` = 1.
- **Contention:** both valid for 4 cycles, req0 sends a=0000/b=0000, req1 sends a=1010/b=0101 → `res_id` sequence 0,1,0,1. `res_y` is 1111 for ID 0 and 0000 for ID 1. `cnt0` = `cnt1` = 2.
- **Back-pressure:** `res_ready` = 0 for 3 cycles with `res_valid` = 1 → `res_y`/`res_id` stable, both readies 0, counters unchanged. On release, the pending request transfers the same cycle.
- **Simultaneous consume and accept:** `res_valid` = 1, `res_ready` = 1, req1 valid with a=1111, b=1111 → `res_valid` stays 1, next `res_y` = 0000 and `res_id` = 1, no bubble.
- **Counter wrap:** 256 transfers from req1 with `CNT_W` = 8 → `cnt1` returns to 0 and `cnt0` stays unchanged.

Source files
------------

// File: rtl/nor_rr_arbiter_pkg.sv
// Shared constants for the round-robin NOR arbiter: default widths, the
// result-register state encoding and the requester IDs.
package nor_rr_arbiter_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } res_state_e;

    localparam logic ID0 = 1'b0;
    localparam logic ID1 = 1'b1;

endpackage

// File: rtl/nor_4bits.sv
// Shared bitwise NOR datapath.
module nor_4bits #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = ~(a | b);

endmodule

// File: rtl/nor_rr_arbiter.sv
// Two-requester round-robin arbiter in front of one nor_4bits unit, with a
// held result register and per-requester accepted-transfer counters.
module nor_rr_arbiter
    import nor_rr_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_y,
    output logic             res_id,
    input  logic             res_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    res_state_e       state_q, state_d;
    logic             last_q, last_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic             free;
    logic             grant0, grant1;
    logic             xfer0, xfer1;
    logic [WIDTH-1:0] op_a, op_b, nor_y;

    // Grant the sole valid requester, or the one that did not win last time.
    assign free   = (state_q == EMPTY) || res_ready;
    assign grant0 = req0_valid && (!req1_valid || (last_q == ID1));
    assign grant1 = req1_valid && (!req0_valid || (last_q == ID0));

    assign req0_ready = rst_n && free && grant0;
    assign req1_ready = rst_n && free && grant1;
    assign xfer0      = req0_valid && req0_ready;
    assign xfer1      = req1_valid && req1_ready;

    assign op_a = grant1 ? req1_a : req0_a;
    assign op_b = grant1 ? req1_b : req0_b;

    nor_4bits #(
        .WIDTH (WIDTH)
    ) u_nor (
        .a (op_a),
        .b (op_b),
        .y (nor_y)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        y_d     = y_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        if (xfer0 || xfer1) begin
            state_d = FULL;
            y_d     = nor_y;
            id_d    = xfer1 ? ID1 : ID0;
            last_d  = xfer1 ? ID1 : ID0;
        end else if ((state_q == FULL) && res_ready) begin
            // Consumed with nothing to replace it; y/id keep their last values.
            state_d = EMPTY;
        end
        if (xfer0) cnt0_d = cnt0_q + CNT_W'(1);
        if (xfer1) cnt1_d = cnt1_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            last_q  <= ID1;
            id_q    <= ID0;
            y_q     <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            y_q     <= y_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_y     = y_q;
    assign res_id    = id_q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;

endmodule
